// File: rtl/hazard_control_unit.sv
// Hazard control unit for a 5-stage pipeline.
// Arbitrates, in priority order, between reset, multi-cycle multiply,
// taken branch/jump (leap) and data hazards. It drives the stall, flush and
// bubble controls, and keeps saturating stall and flush performance counters.
//
// Optional build macro HAZARD_FWD_EN:
//   defined   - a forwarding datapath exists, so only load-use stalls
//   undefined - stall on any RAW match against EX, MEM or WB
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; a multiply start, leap or data hazard may act
// MUL_WAIT | multiply still occupying EX; mul_cnt counts the holds left
module hazard_control_unit #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_destReg,
  input  logic [4:0]  mem_destReg,
  input  logic [4:0]  wb_destReg,
  input  logic        ex_RegWrite,
  input  logic        mem_RegWrite,
  input  logic        wb_RegWrite,
  input  logic        ex_MemToReg,
  input  logic        ex_mul_start,
  input  logic        ex_leap,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
  output logic        ex_hold,
  output logic        mul_busy,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;

  // A single-cycle multiply needs no hold at all, so the FSM never leaves RUN.
  localparam bit         MUL_MULTI  = (MUL_CYCLES >= 2);
  localparam int         MUL_LOAD_I = MUL_MULTI ? (MUL_CYCLES - 2) : 0;
  localparam logic [3:0] MUL_LOAD   = MUL_LOAD_I[3:0];

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_mul_cnt;
  logic [3:0]  w_mul_cnt_nxt;
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_wb_m1, w_wb_m2;
  logic w_load_use;
  logic w_data_hazard;

  function automatic logic src_match(input logic uses, input logic [4:0] rs,
                                     input logic we, input logic [4:0] dest);
    return uses && we && (dest == rs) && (rs != 5'd0);
  endfunction

  assign w_ex_m1  = src_match(id_uses_rs1, id_rs1, ex_RegWrite,  ex_destReg);
  assign w_ex_m2  = src_match(id_uses_rs2, id_rs2, ex_RegWrite,  ex_destReg);
  assign w_mem_m1 = src_match(id_uses_rs1, id_rs1, mem_RegWrite, mem_destReg);
  assign w_mem_m2 = src_match(id_uses_rs2, id_rs2, mem_RegWrite, mem_destReg);
  assign w_wb_m1  = src_match(id_uses_rs1, id_rs1, wb_RegWrite,  wb_destReg);
  assign w_wb_m2  = src_match(id_uses_rs2, id_rs2, wb_RegWrite,  wb_destReg);

  assign w_load_use = ex_MemToReg && (w_ex_m1 || w_ex_m2);

`ifdef HAZARD_FWD_EN
  assign w_data_hazard = w_load_use;
`else
  assign w_data_hazard = w_ex_m1 || w_ex_m2 || w_mem_m1 || w_mem_m2 ||
                         w_wb_m1 || w_wb_m2;
`endif

  // Next-state and pipeline control outputs, in priority order.
  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    ex_hold       = 1'b0;
    mul_busy      = 1'b0;
    if (!reset) begin
      w_state_nxt   = RUN;
      w_mul_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_mul_start && MUL_MULTI) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            w_mul_cnt_nxt = MUL_LOAD;
            w_state_nxt   = MUL_WAIT;
          end else if (ex_leap) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (w_data_hazard) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        MUL_WAIT: begin
          mul_busy = 1'b1;
          if (r_mul_cnt != 4'd0) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            w_mul_cnt_nxt = r_mul_cnt - 4'd1;
          end else begin
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // FSM state and multiply countdown register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= RUN;
      r_mul_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
    end
  end

  // Saturating performance counters for stalled and flushed cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (pc_stall && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
      if (if_id_flush && (r_flush_count != 16'hFFFF))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (MUL_CYCLES 4 and 8) share
// stimulus and are compared every cycle against a cycle-position model.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_destReg, mem_destReg, wb_destReg;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_RegWrite, mem_RegWrite, wb_RegWrite;
  logic       ex_MemToReg, ex_mul_start, ex_leap;

  logic [1:0]  pcs_o, ifs_o, ids_o, flu_o, idb_o, emb_o, hld_o, bsy_o;
  logic [15:0] sc0, sc1, fc0, fc1;

  int n_checks = 0;
  int n_errors = 0;

  int pos [2];
  int msc [2];
  int mfc [2];

  always #5 clk = ~clk;

  hazard_control_unit #(.MUL_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_destReg(ex_destReg), .mem_destReg(mem_destReg), .wb_destReg(wb_destReg),
    .ex_RegWrite(ex_RegWrite), .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite),
    .ex_MemToReg(ex_MemToReg), .ex_mul_start(ex_mul_start), .ex_leap(ex_leap),
    .pc_stall(pcs_o[0]), .if_id_stall(ifs_o[0]), .id_ex_stall(ids_o[0]),
    .if_id_flush(flu_o[0]), .id_ex_bubble(idb_o[0]), .ex_mem_bubble(emb_o[0]),
    .ex_hold(hld_o[0]), .mul_busy(bsy_o[0]),
    .stall_count(sc0), .flush_count(fc0)
  );

  hazard_control_unit #(.MUL_CYCLES(8)) u_dut8 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_destReg(ex_destReg), .mem_destReg(mem_destReg), .wb_destReg(wb_destReg),
    .ex_RegWrite(ex_RegWrite), .mem_RegWrite(mem_RegWrite), .wb_RegWrite(wb_RegWrite),
    .ex_MemToReg(ex_MemToReg), .ex_mul_start(ex_mul_start), .ex_leap(ex_leap),
    .pc_stall(pcs_o[1]), .if_id_stall(ifs_o[1]), .id_ex_stall(ids_o[1]),
    .if_id_flush(flu_o[1]), .id_ex_bubble(idb_o[1]), .ex_mem_bubble(emb_o[1]),
    .ex_hold(hld_o[1]), .mul_busy(bsy_o[1]),
    .stall_count(sc1), .flush_count(fc1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit src_hit(input logic u, input logic [4:0] rs,
                                 input logic we, input logic [4:0] d);
    return u && we && (d == rs) && (rs != 5'd0);
  endfunction

  function automatic bit data_hazard();
    bit e1, e2, hit_any;
    e1 = src_hit(id_uses_rs1, id_rs1, ex_RegWrite, ex_destReg);
    e2 = src_hit(id_uses_rs2, id_rs2, ex_RegWrite, ex_destReg);
    hit_any = e1 || e2 ||
              src_hit(id_uses_rs1, id_rs1, mem_RegWrite, mem_destReg) ||
              src_hit(id_uses_rs2, id_rs2, mem_RegWrite, mem_destReg) ||
              src_hit(id_uses_rs1, id_rs1, wb_RegWrite, wb_destReg) ||
              src_hit(id_uses_rs2, id_rs2, wb_RegWrite, wb_destReg);
`ifdef HAZARD_FWD_EN
    return ex_MemToReg && (e1 || e2);
`else
    return hit_any;
`endif
  endfunction

  // Expected outputs as {pc_stall, if_id_stall, id_ex_stall, ex_hold,
  // ex_mem_bubble, if_id_flush, id_ex_bubble, mul_busy}.
  // pos = which cycle of an ongoing multiply this is (0 = none, k = cycle k+1).
  function automatic logic [7:0] expect_outs(input int i);
    int mc;
    logic [7:0] e;
    mc = (i == 0) ? 4 : 8;
    e = 8'd0;
    if (!reset) e = 8'd0;
    else if (pos[i] > 0) begin
      e[0] = 1'b1;
      if (pos[i] < mc - 1) e[7:3] = 5'b11111;
    end else if (ex_mul_start && mc >= 2) e[7:3] = 5'b11111;
    else if (ex_leap) e[2:1] = 2'b11;
    else if (data_hazard()) begin
      e[7] = 1'b1; e[6] = 1'b1; e[1] = 1'b1;
    end
    return e;
  endfunction

  task automatic check_all();
    logic [7:0] a;
    for (int i = 0; i < 2; i++) begin
      a = {pcs_o[i], ifs_o[i], ids_o[i], hld_o[i], emb_o[i], flu_o[i], idb_o[i], bsy_o[i]};
      chk((i == 0) ? "outs_mc4" : "outs_mc8", {24'd0, a}, {24'd0, expect_outs(i)});
    end
    chk("stall_cnt_mc4", {16'd0, sc0}, msc[0]);
    chk("flush_cnt_mc4", {16'd0, fc0}, mfc[0]);
    chk("stall_cnt_mc8", {16'd0, sc1}, msc[1]);
    chk("flush_cnt_mc8", {16'd0, fc1}, mfc[1]);
  endtask

  task automatic model_update();
    logic [7:0] e;
    int mc;
    for (int i = 0; i < 2; i++) begin
      mc = (i == 0) ? 4 : 8;
      e = expect_outs(i);
      if (!reset) begin
        pos[i] = 0; msc[i] = 0; mfc[i] = 0;
      end else begin
        if (e[7] && msc[i] < 65535) msc[i]++;
        if (e[2] && mfc[i] < 65535) mfc[i]++;
        if (pos[i] > 0) pos[i] = (pos[i] + 1 == mc) ? 0 : pos[i] + 1;
        else if (ex_mul_start && mc >= 2) pos[i] = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_destReg = 0; mem_destReg = 0; wb_destReg = 0;
    ex_RegWrite = 0; mem_RegWrite = 0; wb_RegWrite = 0;
    ex_MemToReg = 0; ex_mul_start = 0; ex_leap = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin pos[i] = 0; msc[i] = 0; mfc[i] = 0; end
    idle();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();

    // Load-use on r5 for one cycle.
    ex_MemToReg = 1; ex_RegWrite = 1; ex_destReg = 5; id_rs1 = 5; id_uses_rs1 = 1;
    step();
    chk("loaduse_stall_cnt", {16'd0, sc0}, 32'd1);
    idle(); step();

    // Register 0 never hazards.
    ex_MemToReg = 1; ex_RegWrite = 1; ex_destReg = 0; id_rs1 = 0; id_uses_rs1 = 1;
    step();
    idle(); step();

    // Multiply start held for four cycles, then drain the longer instance.
    ex_mul_start = 1;
    repeat (4) step();
    ex_mul_start = 0;
    repeat (8) step();

    // Leap with a simultaneous load-use on r9.
    ex_leap = 1; ex_MemToReg = 1; ex_RegWrite = 1; ex_destReg = 9;
    id_rs1 = 9; id_uses_rs1 = 1;
    step();
    idle(); step();

    // MEM-stage RAW on r7: stall depends on forwarding build.
    mem_RegWrite = 1; mem_destReg = 7; id_rs2 = 7; id_uses_rs2 = 1;
    step();
    idle(); step();

    // Mid-multiply reset: MUL_CYCLES=8 instance at mul_cnt==2.
    ex_mul_start = 1; step();
    ex_mul_start = 0;
    repeat (4) step();
    reset = 1'b0; step();
    reset = 1'b1;
    repeat (3) step();

    // Randomized traffic with a small register pool to provoke matches.
    repeat (3000) begin
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_uses_rs1  = 1'($urandom);
      id_uses_rs2  = 1'($urandom);
      ex_destReg   = 5'($urandom_range(0, 3));
      mem_destReg  = 5'($urandom_range(0, 3));
      wb_destReg   = 5'($urandom_range(0, 3));
      ex_RegWrite  = 1'($urandom);
      mem_RegWrite = 1'($urandom);
      wb_RegWrite  = 1'($urandom);
      ex_MemToReg  = 1'($urandom);
      ex_mul_start = ($urandom_range(0, 7) == 0);
      ex_leap      = ($urandom_range(0, 5) == 0);
      reset        = ($urandom_range(0, 63) != 0);
      step();
    end

    // Stall counter saturation: hold a load-use hazard long enough to wrap.
    idle();
    reset = 1'b0; step();
    reset = 1'b1;
    ex_MemToReg = 1; ex_RegWrite = 1; ex_destReg = 3; id_rs1 = 3; id_uses_rs1 = 1;
    repeat (65540) step();
    chk("stall_saturate", {16'd0, sc0}, 32'h0000FFFF);
    idle(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
